cpu_req_queue: RTL and testbench

CPU-side request queue sitting directly upstream of the cache top level. It buffers up to DEPTH CPU read/write/flush requests and issues them one at a time on the cache's `cpu_request`/`cpu_addr`/`cpu_wdata` port. It waits for `cache_complete` (read/write) or `flush_complete` (flush), then returns a response to the CPU with read data. Only one cache transaction is outstanding at any time.

---
 rtl/cpu_req_queue.sv | 166 ++++++++++++++++
 tb/tb_cpu_req_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_queue.sv
// CPU request queue feeding the cache: buffers read/write/flush requests and
// runs one cache transaction at a time. Optional watchdog: CPU_REQ_QUEUE_TIMEOUT_EN.
module cpu_req_queue #(
    parameter int WIDTH_A        = 32,
    parameter int WIDTH_D        = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [WIDTH_A-1:0] req_addr,
    input  logic [WIDTH_D-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_op,
    output logic [WIDTH_D-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic [1:0]         cpu_request,
    output logic [WIDTH_A-1:0] cpu_addr,
    output logic [WIDTH_D-1:0] cpu_wdata,
    input  logic               cache_ready,
    input  logic               cache_complete,
    input  logic               flush_complete,
    input  logic [WIDTH_D-1:0] cpu_rdata
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t state;

    logic [1:0]         op_mem    [DEPTH];
    logic [WIDTH_A-1:0] addr_mem  [DEPTH];
    logic [WIDTH_D-1:0] wdata_mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic          queued;
    logic [1:0]    cur_op;
    logic          done;

    assign full      = (count == (PW+1)'(DEPTH));
    assign req_ready = !full;
    assign queued    = (count != '0);
    // Illegal op 00 completes the handshake but never occupies a slot.
    assign push      = req_valid && req_ready && (req_op != OP_NONE);
    assign pop       = (state == ISSUE) && cache_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]    <= req_op;
            addr_mem[wr_ptr]  <= req_addr;
            wdata_mem[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign cpu_request = (state == ISSUE) ? op_mem[rd_ptr]    : OP_NONE;
    assign cpu_addr    = (state == ISSUE) ? addr_mem[rd_ptr]  : '0;
    assign cpu_wdata   = (state == ISSUE) ? wdata_mem[rd_ptr] : '0;

    // Only the completion pulse that matches the outstanding op counts.
    assign done = (cur_op == OP_FLUSH) ? flush_complete : cache_complete;

`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tcnt;
    logic          rsp_err_q;

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_op    <= OP_NONE;
            rsp_valid <= 1'b0;
            rsp_op    <= 2'b00;
            rsp_rdata <= '0;
`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
            tcnt      <= '0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (queued)
                        state <= ISSUE;
                end
                ISSUE: begin
                    if (cache_ready) begin
                        cur_op <= op_mem[rd_ptr];
                        state  <= WAIT;
`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
                        tcnt   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (done) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_op    <= cur_op;
                        rsp_rdata <= (cur_op == OP_READ) ? cpu_rdata : '0;
`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
                        rsp_err_q <= 1'b0;
                    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_op    <= cur_op;
                        rsp_rdata <= '0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= queued ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_req_queue.sv
// Self-checking bench for cpu_req_queue: scoreboard of expected issues/responses
// plus a small cache model driven from per-scenario tasks.
module tb_cpu_req_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  cpu_request;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cache_ready = 1'b0;
    logic        cache_complete = 1'b0;
    logic        flush_complete = 1'b0;
    logic [31:0] cpu_rdata = '0;

    always #5 clk = ~clk;

    cpu_req_queue #(
        .WIDTH_A(32),
        .WIDTH_D(32),
        .DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cpu_request(cpu_request), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cache_ready(cache_ready), .cache_complete(cache_complete),
        .flush_complete(flush_complete), .cpu_rdata(cpu_rdata)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // observations captured by serve()
    bit          obs_ok;
    int          obs_wait;
    logic [1:0]  obs_iop;
    logic [31:0] obs_iaddr, obs_iwdata;
    logic [1:0]  obs_rop;
    logic [31:0] obs_rdata;
    logic        obs_err;

    function automatic logic [31:0] model_rdata(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted (bounded); expected response queued on acceptance.
    task automatic push_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err, output bit ok);
        exp_t e;
        int   w;
        ok = 1'b0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        for (w = 0; w < 50; w++) begin
            if (req_ready) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
        req_valid = 1'b0; req_op = 2'b00;
        if (ok && op != 2'b00) begin
            e.op = op; e.addr = addr; e.wdata = wdata; e.rdata = exp_rdata; e.err = exp_err;
            sb.push_back(e);
        end
    endtask

    task automatic wait_issue(output bit ok, output int waited);
        waited = 0;
        while (cpu_request === 2'b00 && waited < 50) begin
            tick;
            waited++;
        end
        ok = (cpu_request !== 2'b00);
    endtask

    // Cache model: accept the head, complete after lat cycles, then take the response.
    task automatic serve(input int lat);
        int w;
        obs_ok = 1'b0;
        wait_issue(obs_ok, obs_wait);
        if (!obs_ok) return;
        obs_ok = 1'b0;
        obs_iop = cpu_request; obs_iaddr = cpu_addr; obs_iwdata = cpu_wdata;
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        repeat (lat) tick;
        if (obs_iop == 2'b11) flush_complete = 1'b1;
        else begin
            cache_complete = 1'b1;
            cpu_rdata = model_rdata(obs_iaddr);
        end
        tick;
        cache_complete = 1'b0; flush_complete = 1'b0; cpu_rdata = $urandom;
        for (w = 0; w < 20 && !rsp_valid; w++) tick;
        if (!rsp_valid) return;
        obs_rop = rsp_op; obs_rdata = rsp_rdata; obs_err = rsp_err;
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        obs_ok = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({rsp_valid, rsp_op, rsp_rdata, rsp_err} !== '0) begin n_bad++; $display("FAIL reset_rsp: got v=%b op=%b d=%h e=%b want all 0", rsp_valid, rsp_op, rsp_rdata, rsp_err); end
        n_cmp++; if ({cpu_request, cpu_addr, cpu_wdata} !== '0) begin n_bad++; $display("FAIL reset_cpu: got req=%b a=%h d=%h want all 0", cpu_request, cpu_addr, cpu_wdata); end
        rst = 1'b0;
        tick;
        n_cmp++; if (req_ready !== 1'b1 || cpu_request !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle: got rdy=%b req=%b want 1/00", req_ready, cpu_request); end
    endtask

    task automatic test_single_read;
        bit   ok;
        exp_t e;
        cache_ready = 1'b1;
        push_req(2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL read_push: got no accept want accept"); end
        n_cmp++; if (cpu_request !== 2'b00) begin n_bad++; $display("FAIL read_idle_after_push: got %b want 00", cpu_request); end
        tick;
        n_cmp++; if (cpu_request !== 2'b01 || cpu_addr !== 32'h100) begin n_bad++; $display("FAIL read_issue: got %b/%h want 01/00000100", cpu_request, cpu_addr); end
        tick;
        cache_ready = 1'b0;
        n_cmp++; if (cpu_request !== 2'b00) begin n_bad++; $display("FAIL read_issue_one_cycle: got %b want 00", cpu_request); end
        repeat (2) tick;
        cache_complete = 1'b1; cpu_rdata = 32'hDEADBEEF;
        tick;
        cache_complete = 1'b0; cpu_rdata = 32'h0;
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_bad++; $display("FAIL read_rsp: got v=%b op=%b d=%h e=%b want 1/%b/%h/%b", rsp_valid, rsp_op, rsp_rdata, rsp_err, e.op, e.rdata, e.err); end
        tick;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL read_rsp_hold: got v=%b d=%h want 1/%h", rsp_valid, rsp_rdata, e.rdata); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0 || cpu_request !== 2'b00) begin n_bad++; $display("FAIL read_rsp_done: got v=%b req=%b want 0/00", rsp_valid, cpu_request); end
    endtask

    task automatic test_backpressure;
        bit   ok;
        int   w;
        int   bad;
        exp_t e;
        push_req(2'b10, 32'h200, 32'h1234, 32'h0, 1'b0, ok);
        wait_issue(ok, w);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_issue_timeout: got no request want 10"); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (cpu_request !== 2'b10 || cpu_addr !== 32'h200 || cpu_wdata !== 32'h1234) bad++;
            tick;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        tick;
        cache_complete = 1'b1; cpu_rdata = 32'hFFFF_FFFF;
        tick;
        cache_complete = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL bp_rsp: got v=%b op=%b d=%h want 1/%b/%h", rsp_valid, rsp_op, rsp_rdata, e.op, e.rdata); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    endtask

    task automatic test_full_fifo;
        logic [1:0]  ops   [5];
        logic [31:0] addrs [5];
        bit          ok;
        exp_t        e;
        ops = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        addrs = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h410};
        for (int i = 0; i < 4; i++) begin
            push_req(ops[i], addrs[i], addrs[i] + 32'h1000,
                     (ops[i] == 2'b01) ? model_rdata(addrs[i]) : 32'h0, 1'b0, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_push%0d: got no accept want accept", i); end
        end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_low: got %b want 0", req_ready); end
        n_cmp++; if (cpu_request !== 2'b01 || cpu_addr !== 32'h400) begin n_bad++; $display("FAIL full_head_issue: got %b/%h want 01/00000400", cpu_request, cpu_addr); end
        req_valid = 1'b1; req_op = ops[4]; req_addr = addrs[4]; req_wdata = addrs[4] + 32'h1000;
        e.op = ops[4]; e.addr = addrs[4]; e.wdata = addrs[4] + 32'h1000; e.rdata = 32'h0; e.err = 1'b0;
        sb.push_back(e);
        tick;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL full_still_full: got %b want 0", req_ready); end
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL full_reopen: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0; req_op = 2'b00;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL full_refill: got %b want 0", req_ready); end
        cache_complete = 1'b1; cpu_rdata = model_rdata(32'h400);
        tick;
        cache_complete = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL full_rsp0: got v=%b op=%b d=%h want 1/%b/%h", rsp_valid, rsp_op, rsp_rdata, e.op, e.rdata); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            serve(i % 3);
            e = sb.pop_front();
            n_cmp++; if (!obs_ok) begin n_bad++; $display("FAIL full_serve%0d: got no completion want completion", i); end
            n_cmp++; if (obs_iop !== e.op || obs_iaddr !== e.addr || obs_iwdata !== e.wdata) begin n_bad++; $display("FAIL full_issue%0d: got %b/%h/%h want %b/%h/%h", i, obs_iop, obs_iaddr, obs_iwdata, e.op, e.addr, e.wdata); end
            n_cmp++; if (obs_rop !== e.op || obs_rdata !== e.rdata || obs_err !== e.err) begin n_bad++; $display("FAIL full_rsp%0d: got %b/%h/%b want %b/%h/%b", i, obs_rop, obs_rdata, obs_err, e.op, e.rdata, e.err); end
        end
    endtask

    task automatic test_flush;
        bit   ok;
        int   w;
        int   early;
        exp_t e;
        push_req(2'b11, 32'h300, 32'hBBBB, 32'h0, 1'b0, ok);
        wait_issue(ok, w);
        n_cmp++; if (cpu_request !== 2'b11) begin n_bad++; $display("FAIL flush_issue: got %b want 11", cpu_request); end
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        cache_complete = 1'b1; cpu_rdata = 32'h5555_5555;
        tick;
        cache_complete = 1'b0;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid !== 1'b0) early++;
            tick;
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL flush_ignore_cc: got %0d early valid cycles want 0", early); end
        flush_complete = 1'b1; tick; flush_complete = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_bad++; $display("FAIL flush_rsp: got v=%b op=%b d=%h e=%b want 1/%b/%h/%b", rsp_valid, rsp_op, rsp_rdata, rsp_err, e.op, e.rdata, e.err); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    endtask

    task automatic test_illegal_drop;
        int act;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h999;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b want 1", req_ready); end
        tick;
        req_valid = 1'b0;
        act = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_request !== 2'b00 || rsp_valid !== 1'b0) act++;
            tick;
        end
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL drop_no_issue: got %0d active cycles want 0", act); end
    endtask

    task automatic test_back_to_back;
        bit   ok;
        exp_t e;
        logic [31:0] addrs [3];
        logic [1:0]  ops   [3];
        addrs = '{32'h500, 32'h504, 32'h508};
        ops = '{2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++)
            push_req(ops[i], addrs[i], 32'hC0DE_0000 | addrs[i],
                     (ops[i] == 2'b01) ? model_rdata(addrs[i]) : 32'h0, 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            serve(1);
            e = sb.pop_front();
            n_cmp++; if (!obs_ok || obs_iaddr !== e.addr || obs_iwdata !== e.wdata || obs_rop !== e.op || obs_rdata !== e.rdata) begin n_bad++; $display("FAIL b2b_txn%0d: got ok=%b a=%h w=%h op=%b d=%h want 1/%h/%h/%b/%h", i, obs_ok, obs_iaddr, obs_iwdata, obs_rop, obs_rdata, e.addr, e.wdata, e.op, e.rdata); end
            if (i > 0) begin
                n_cmp++; if (obs_wait != 0) begin n_bad++; $display("FAIL b2b_bubble%0d: got %0d idle cycles want 0", i, obs_wait); end
            end
        end
    endtask

    task automatic test_push_during_resp;
        bit   ok;
        int   w;
        exp_t e;
        push_req(2'b01, 32'h600, 32'h0, model_rdata(32'h600), 1'b0, ok);
        wait_issue(ok, w);
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        cache_complete = 1'b1; cpu_rdata = model_rdata(32'h600);
        tick;
        cache_complete = 1'b0;
        push_req(2'b10, 32'h604, 32'h7777, 32'h0, 1'b0, ok);
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata) begin n_bad++; $display("FAIL resp_push_rsp: got v=%b op=%b d=%h want 1/%b/%h", rsp_valid, rsp_op, rsp_rdata, e.op, e.rdata); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        n_cmp++; if (cpu_request !== 2'b10 || cpu_addr !== 32'h604) begin n_bad++; $display("FAIL resp_push_issue: got %b/%h want 10/00000604", cpu_request, cpu_addr); end
        serve(0);
        e = sb.pop_front();
        n_cmp++; if (!obs_ok || obs_rop !== e.op || obs_rdata !== e.rdata || obs_iwdata !== e.wdata) begin n_bad++; $display("FAIL resp_push_txn: got ok=%b op=%b d=%h w=%h want 1/%b/%h/%h", obs_ok, obs_rop, obs_rdata, obs_iwdata, e.op, e.rdata, e.wdata); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int w;
        int act;
        push_req(2'b01, 32'h700, 32'h0, model_rdata(32'h700), 1'b0, ok);
        push_req(2'b10, 32'h704, 32'h1, 32'h0, 1'b0, ok);
        push_req(2'b01, 32'h708, 32'h0, model_rdata(32'h708), 1'b0, ok);
        wait_issue(ok, w);
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({cpu_request, cpu_addr, cpu_wdata} !== '0) begin n_bad++; $display("FAIL rstmid_cpu: got req=%b a=%h d=%h want all 0", cpu_request, cpu_addr, cpu_wdata); end
        n_cmp++; if ({rsp_valid, rsp_op, rsp_rdata, rsp_err} !== '0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_rsp: got v=%b op=%b d=%h e=%b rdy=%b want 0/0/0/0/1", rsp_valid, rsp_op, rsp_rdata, rsp_err, req_ready); end
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        tick;
        cache_complete = 1'b1; cpu_rdata = 32'h1111_2222;
        tick;
        cache_complete = 1'b0;
        act = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b0 || cpu_request !== 2'b00) act++;
            tick;
        end
        n_cmp++; if (act != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", act); end
    endtask

`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
    task automatic test_timeout;
        bit   ok;
        int   w;
        int   early;
        exp_t e;
        push_req(2'b01, 32'h800, 32'h0, 32'h0, 1'b1, ok);
        wait_issue(ok, w);
        cache_ready = 1'b1; tick; cache_ready = 1'b0;
        early = 0;
        for (int i = 0; i < 7; i++) begin
            tick;
            if (rsp_valid !== 1'b0) early++;
        end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_early: got %0d early valid cycles want 0", early); end
        tick;
        e = sb.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_op !== e.op || rsp_rdata !== e.rdata || rsp_err !== e.err) begin n_bad++; $display("FAIL to_rsp: got v=%b op=%b d=%h e=%b want 1/%b/%h/%b", rsp_valid, rsp_op, rsp_rdata, rsp_err, e.op, e.rdata, e.err); end
        cache_complete = 1'b1; cpu_rdata = 32'h9999_9999;
        tick;
        cache_complete = 1'b0;
        n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_late_cc: got d=%h e=%b want 0/1", rsp_rdata, rsp_err); end
        rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_done: got %b want 0", rsp_valid); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_read;
        test_backpressure;
        test_full_fifo;
        test_flush;
        test_illegal_drop;
        test_back_to_back;
        test_push_during_resp;
        test_reset_mid;
`ifdef CPU_REQ_QUEUE_TIMEOUT_EN
        test_timeout;
`endif
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drained: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
